// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the prio_encoder_rr block.
//   MODE_FIXED / MODE_RR : values of the run-time arbitration mode input
//   multi_hot()          : true when more than one bit of a (zero-extended)
//                          request vector is set
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest supported request vector; callers zero-extend to this width.
  localparam int MAX_N = 256;

  // v & (v-1) clears the lowest set bit; anything left means >1 bit was set.
  function automatic logic multi_hot(input logic [MAX_N-1:0] v);
    return |(v & (v - MAX_N'(1)));
  endfunction

endpackage

// File: rtl/prio_encoder_rr_prio_pick.sv
// Combinational request picker.
//   vec   : request vector (N bits)
//   start : round-robin scan start index (0..N-1)
//   mode  : MODE_FIXED = highest set index wins,
//           MODE_RR    = first set bit at or above start, wrapping N-1 -> 0
//   idx   : selected index (don't-care when any = 0)
//   any   : at least one request bit is set
module prio_pick
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] dbl_masked;
  logic [W:0]     rr_pos;
  logic [W-1:0]   rr_idx;
  logic [W-1:0]   fixed_idx;

  // Round robin by doubling the vector: the lower copy only keeps bits at or
  // above start, the upper copy is complete and supplies the wrapped part.
  // The lowest set bit of the doubled vector is then the round-robin winner.
  generate
    for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
      if (gi < N) begin : g_low
        assign dbl_masked[gi] = vec[gi] & (W'(gi) >= start);
      end else begin : g_high
        assign dbl_masked[gi] = vec[gi-N];
      end
    end
  endgenerate

  always_comb begin
    rr_pos = '0;
    // Scan downward so the last hit is the lowest set position.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl_masked[j]) rr_pos = (W+1)'(j);
    end
  end

  // Fold a hit in the upper copy back onto 0..N-1.
  assign rr_idx = (rr_pos >= (W+1)'(N)) ? W'(rr_pos - (W+1)'(N)) : W'(rr_pos);

  always_comb begin
    fixed_idx = '0;
    // Scan upward so the last hit is the highest set index.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) fixed_idx = W'(i);
    end
  end

  assign idx = (mode == MODE_RR) ? rr_idx : fixed_idx;
  assign any = |vec;

endmodule

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder with registered output and valid/ready
// handshake. One grant per cycle; a stalled grant is held, new requests
// during a stall are ignored (not queued).
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : request vector, bit i = line i requesting
//   mode      : 0 = fixed priority (highest index), 1 = round robin
//   out_ready : consumer accepts the held grant this cycle
//   out_valid : out_idx/out_multi hold a captured grant
//   out_idx   : granted request index
//   out_multi : more than one req bit was set at capture
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
);

  logic         valid_reg;
  logic [W-1:0] idx_reg;
  logic         multi_reg;
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         pick_multi;
  logic         free;

  prio_pick #(.N(N), .W(W)) u_pick (
    .vec   (req),
    .start (ptr_reg),
    .mode  (mode),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pick_multi = multi_hot(MAX_N'(req));
  assign free       = !valid_reg || out_ready;

  // Explicit wrap keeps ptr inside 0..N-1 for non-power-of-two N.
  assign ptr_next = (pick_idx == W'(N-1)) ? '0 : pick_idx + W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      multi_reg <= 1'b0;
      ptr_reg   <= '0;
    end else if (free) begin
      if (pick_any) begin
        valid_reg <= 1'b1;
        idx_reg   <= pick_idx;
        multi_reg <= pick_multi;
        if (mode == MODE_RR) ptr_reg <= ptr_next;
      end else begin
        // Idle: idx/multi keep their last (don't-care) values.
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_idx   = idx_reg;
  assign out_multi = multi_reg;

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;

  typedef struct {
    int idx;
    bit multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       out_ready;
  logic [3:0] req4;
  logic [4:0] req5;
  logic       out_valid4, out_multi4;
  logic [1:0] out_idx4;
  logic       out_valid5, out_multi5;
  logic [2:0] out_idx5;

  int checks = 0;
  int failures = 0;

  exp_t q4[$];
  exp_t q5[$];
  int   p4 = 0;
  int   p5 = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid4), .out_idx(out_idx4), .out_multi(out_multi4)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid5), .out_idx(out_idx5), .out_multi(out_multi5)
  );

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, expv);
    end
  endtask

  // Reference choice straight from the arbitration rules.
  function automatic int ref_pick(input int n, input logic [7:0] r, input bit m, input int p);
    if (!m) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  // Model: the output slot is free when nothing is held (the monitor
  // retires a held grant on the negedge when out_ready is high).
  always @(posedge clk) begin
    if (rst_n) begin
      if (q4.size() == 0 && req4 != 0) begin
        int i4;
        i4 = ref_pick(4, 8'(req4), mode, p4);
        q4.push_back('{i4, $countones(req4) > 1});
        if (mode) p4 = (i4 + 1) % 4;
      end
      if (q5.size() == 0 && req5 != 0) begin
        int i5;
        i5 = ref_pick(5, 8'(req5), mode, p5);
        q5.push_back('{i5, $countones(req5) > 1});
        if (mode) p5 = (i5 + 1) % 5;
      end
    end
  end

  // Monitors: compare whatever the DUT is presenting against the held
  // expectation; retire it when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q4.size() != 0) begin
        check("n4_valid", int'(out_valid4), 1);
        check("n4_idx", int'(out_idx4), q4[0].idx);
        check("n4_multi", int'(out_multi4), int'(q4[0].multi));
        $display("n4 grant idx=%0d multi=%0d ready=%0d", out_idx4, out_multi4, out_ready);
        if (out_ready) void'(q4.pop_front());
      end else begin
        check("n4_idle_valid", int'(out_valid4), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q5.size() != 0) begin
        check("n5_valid", int'(out_valid5), 1);
        check("n5_idx", int'(out_idx5), q5[0].idx);
        check("n5_multi", int'(out_multi5), int'(q5[0].multi));
        $display("n5 grant idx=%0d multi=%0d ready=%0d", out_idx5, out_multi5, out_ready);
        if (out_ready) void'(q5.pop_front());
      end else begin
        check("n5_idle_valid", int'(out_valid5), 0);
      end
    end
  end

  // Apply inputs just after a rising edge; they are sampled at the next one.
  task automatic step(input bit m, input bit rdy, input logic [3:0] r4, input logic [4:0] r5);
    @(posedge clk);
    #1;
    mode = m;
    out_ready = rdy;
    req4 = r4;
    req5 = r5;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid4"}, int'(out_valid4), 0);
    check({tag, "_idx4"}, int'(out_idx4), 0);
    check({tag, "_multi4"}, int'(out_multi4), 0);
    check({tag, "_valid5"}, int'(out_valid5), 0);
    check({tag, "_idx5"}, int'(out_idx5), 0);
    check({tag, "_multi5"}, int'(out_multi5), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    out_ready = 1'b1;
    req4 = '0;
    req5 = '0;
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed priority, one-hot walk then idle.
    step(0, 1, 4'b0001, 5'b00001);
    step(0, 1, 4'b0010, 5'b00010);
    step(0, 1, 4'b0100, 5'b10100);
    step(0, 1, 4'b1000, 5'b01000);
    step(0, 1, 4'b0000, 5'b00000);
    step(0, 1, 4'b0000, 5'b00000);

    // Multi-hot capture, then a 3-cycle stall while req changes.
    step(0, 1, 4'b1011, 5'b00110);
    step(0, 0, 4'b0001, 5'b00001);
    step(0, 0, 4'b0001, 5'b00001);
    step(0, 0, 4'b0001, 5'b00001);
    step(0, 1, 4'b0001, 5'b00001);
    step(0, 1, 4'b0000, 5'b00000);

    // Round robin, all requesting (N=4) and sparse wrap (N=5).
    for (int i = 0; i < 6; i++) step(1, 1, 4'b1111, 5'b10001);
    step(1, 1, 4'b0000, 5'b00000);
    step(1, 1, 4'b0000, 5'b00000);

    // Stalled grant, then an asynchronous reset between edges.
    step(1, 1, 4'b1111, 5'b11111);
    step(1, 0, 4'b1111, 5'b11111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    q4.delete();
    q5.delete();
    p4 = 0;
    p5 = 0;
    #1;
    rst_n = 1'b1;
    step(1, 1, 4'b1111, 5'b11111);
    step(1, 1, 4'b0000, 5'b00000);
    step(1, 1, 4'b0000, 5'b00000);

    // Mode switching with a live round-robin pointer.
    step(1, 1, 4'b0011, 5'b00011);
    step(1, 1, 4'b0011, 5'b00011);
    step(0, 1, 4'b0111, 5'b00111);
    step(0, 1, 4'b0111, 5'b00111);
    step(1, 1, 4'b0011, 5'b00011);
    step(1, 1, 4'b0000, 5'b00000);

    // Random traffic with random stalls and mode flips.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           4'($urandom), 5'($urandom));
    end

    // Drain and confirm nothing expected is left outstanding.
    step(0, 1, 4'b0000, 5'b00000);
    step(0, 1, 4'b0000, 5'b00000);
    step(0, 1, 4'b0000, 5'b00000);
    @(negedge clk);
    #1;
    check("drain_q4", q4.size(), 0);
    check("drain_q5", q5.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
